// File: rtl/apu_cluster_package.sv
// Shared constants and result types for the APU cluster result queues.
package apu_cluster_package;

  localparam int unsigned FP_WIDTH      = 32;
  localparam int unsigned NUSFLAGS_DIV  = 5;
  localparam int unsigned DIV_TAG_WIDTH = 5;

  // One divider result as stored in a result queue.
  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [DIV_TAG_WIDTH-1:0] tag;
    logic [NUSFLAGS_DIV-1:0]  status;
  } div_res_t;

endpackage

// File: rtl/apu_result_fifo.sv
// In-order result FIFO: DEPTH entries, wrap-around pointers (any DEPTH >= 2),
// registered occupancy count. Head entry is read straight from storage.
module apu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage write; entries are cleared on reset so the head is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_i) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // Pointers advance modulo DEPTH; count tracks push/pop (both -> unchanged).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_r <= (wr_ptr_r == PW'(DEPTH-1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_r <= (rd_ptr_r == PW'(DEPTH-1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign count_o = count_r;

endmodule

// File: rtl/fp_div_result_queue.sv
// Issue/credit front end for the fixed-latency FP divider plus the result FIFO.
// Every issued divide holds a credit until its result is popped, so the FIFO
// always has room for whatever the (non-stallable) divider returns.
module fp_div_result_queue
  import apu_cluster_package::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned FP_W       = FP_WIDTH,
  parameter int unsigned STAT_WIDTH = NUSFLAGS_DIV
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  req_ready_o,
  output logic                  div_en_o,
  output logic [TAG_WIDTH-1:0]  div_tag_o,
  input  logic                  div_valid_i,
  input  logic [FP_W-1:0]       div_res_i,
  input  logic [TAG_WIDTH-1:0]  div_tag_i,
  input  logic [STAT_WIDTH-1:0] div_status_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [FP_W-1:0]       res_data_o,
  output logic [TAG_WIDTH-1:0]  res_tag_o,
  output logic [STAT_WIDTH-1:0] res_status_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CW      = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = FP_W + TAG_WIDTH + STAT_WIDTH;

  logic [CW-1:0]      inflight_r;
  logic [CW-1:0]      count_s;
  logic               err_r;
  logic               issue_s;
  logic               pop_s;
  logic               push_s;
  logic               retire_s;
  logic               full_s;
  logic               err_set_s;
  logic [ENTRY_W-1:0] head_s;

  // Credits come from registered state only: a pop frees a slot next cycle.
  assign req_ready_o = ({1'b0, inflight_r} + {1'b0, count_s}) < (CW+1)'(DEPTH);
  assign issue_s     = req_valid_i & req_ready_o;
  assign div_en_o    = issue_s;
  assign div_tag_o   = req_tag_i;

  assign full_s      = (count_s == CW'(DEPTH));
  assign res_valid_o = (count_s != {CW{1'b0}});
  assign pop_s       = res_valid_o & res_ready_i;

  // A result with nothing in flight, or arriving into a full FIFO with no pop,
  // is a protocol violation: it is dropped and flagged.
  assign retire_s  = div_valid_i & (inflight_r != {CW{1'b0}});
  assign push_s    = retire_s & (~full_s | pop_s);
  assign err_set_s = div_valid_i & ((inflight_r == {CW{1'b0}}) | (full_s & ~pop_s));

  // In-flight divide counter; never decrements below zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_r <= {CW{1'b0}};
    end else begin
      case ({issue_s, retire_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  apu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({div_res_i, div_tag_i, div_status_i}),
    .rdata_o (head_s),
    .count_o (count_s)
  );

  assign res_data_o   = head_s[ENTRY_W-1 -: FP_W];
  assign res_tag_o    = head_s[STAT_WIDTH +: TAG_WIDTH];
  assign res_status_o = head_s[STAT_WIDTH-1:0];
  assign busy_o       = (inflight_r != {CW{1'b0}}) | res_valid_o;
  assign err_o        = err_r;

endmodule

// File: tb/tb_fp_div_result_queue.sv
// Bench for fp_div_result_queue with a latency-2 divider model and a scoreboard.
module tb_fp_div_result_queue;
  import apu_cluster_package::*;

  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] FOUR = 32'h40800000;
  localparam logic [31:0] SIX  = 32'h40C00000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [4:0]  req_tag_i = 5'd0;
  logic        req_ready_o, div_en_o;
  logic [4:0]  div_tag_o;
  logic        div_valid_i;
  logic [31:0] div_res_i;
  logic [4:0]  div_tag_i;
  logic [4:0]  div_status_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic [4:0]  res_tag_o;
  logic [4:0]  res_status_o;
  logic        busy_o, err_o;

  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        inj = 1'b0;
  logic [31:0] tbl [4];

  int n_checks = 0;
  int n_pass   = 0;
  div_res_t sb[$];

  always #5 clk_i = ~clk_i;

  fp_div_result_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_tag_i(req_tag_i), .req_ready_o(req_ready_o),
    .div_en_o(div_en_o), .div_tag_o(div_tag_o),
    .div_valid_i(div_valid_i), .div_res_i(div_res_i), .div_tag_i(div_tag_i),
    .div_status_i(div_status_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_tag_o(res_tag_o), .res_status_o(res_status_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Single-precision divide through real arithmetic (normal, nonzero operands).
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    real ra, rb, q;
    logic [63:0] qb;
    logic [10:0] e;
    ra = $bitstoreal({a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0});
    rb = $bitstoreal({b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0});
    q  = ra / rb;
    qb = $realtobits(q);
    e  = qb[62:52] - 11'd896;
    return {qb[63], e[7:0], qb[51:29]};
  endfunction

  function automatic logic [4:0] stat_of(input logic [4:0] t);
    return t ^ 5'h15;
  endfunction

  // Divider model: fixed latency 2, reset by the same rst_ni.
  logic        v1, v2;
  logic [4:0]  t1, t2;
  logic [31:0] r1, r2;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1 <= 1'b0; v2 <= 1'b0; t1 <= 5'd0; t2 <= 5'd0; r1 <= 32'd0; r2 <= 32'd0;
    end else begin
      v1 <= div_en_o; t1 <= div_tag_o; r1 <= fdiv(op_a, op_b);
      v2 <= v1;       t2 <= t1;        r2 <= r1;
    end
  end
  assign div_valid_i  = v2 | inj;
  assign div_res_i    = r2;
  assign div_tag_i    = t2;
  assign div_status_i = stat_of(t2);

  // Drive one cycle from a negedge; report issue/pop and the head seen this cycle.
  task automatic step(input logic rv, input logic [4:0] tg, input logic [31:0] a,
                      input logic [31:0] b, input logic rr,
                      output logic iss, output logic pop, output div_res_t head);
    div_res_t e;
    req_valid_i = rv; req_tag_i = tg; op_a = a; op_b = b; res_ready_i = rr;
    #1;
    iss  = rv & req_ready_o;
    pop  = res_valid_o & rr;
    head = '{res: res_data_o, tag: res_tag_o, status: res_status_o};
    if (iss) begin
      e = '{res: fdiv(a, b), tag: tg, status: stat_of(tg)};
      sb.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready_o); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_checks++; if (div_en_o !== 1'b0) $display("FAIL reset_div_en: got %b want 0", div_en_o); else n_pass++;
  endtask

  task automatic test_single_op();
    logic iss, pop; div_res_t h, e;
    step(1'b1, 5'd3, SIX, TWO, 1'b1, iss, pop, h);
    n_checks++; if (iss !== 1'b1) $display("FAIL single_issue: got %b want 1", iss); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 5'd0, ONE, ONE, 1'b1, iss, pop, h);
      n_checks++;
      if (pop !== (k == 3)) $display("FAIL single_latency: cycle %0d valid %b want %b", k, pop, (k == 3));
      else n_pass++;
      if (pop && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (h !== e) $display("FAIL single_entry: got %h want %h", h, e); else n_pass++;
        n_checks++; if (h.res !== 32'h40400000) $display("FAIL single_value: got %h want 40400000", h.res); else n_pass++;
        n_checks++; if (h.tag !== 5'd3) $display("FAIL single_tag: got %0d want 3", h.tag); else n_pass++;
      end
    end
    n_checks++; if (busy_o !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic iss, pop; div_res_t h; int n_iss;
    n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'(i), tbl[i % 4], TWO, 1'b0, iss, pop, h);
      if (iss) n_iss++;
    end
    n_checks++; if (n_iss != 4) $display("FAIL bp_issues: got %0d want 4", n_iss); else n_pass++;
    n_checks++; if (req_ready_o !== 1'b0) $display("FAIL bp_ready: got %b want 0", req_ready_o); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b1) $display("FAIL bp_valid: got %b want 1", res_valid_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL bp_err: got %b want 0", err_o); else n_pass++;
    n_checks++; if (res_tag_o !== 5'd0) $display("FAIL bp_head_stable: got %0d want 0", res_tag_o); else n_pass++;
  endtask

  task automatic test_pop_at_full();
    logic iss, pop; div_res_t h, e; int n;
    // Pop at full while requesting: the freed slot is not usable this cycle.
    step(1'b1, 5'd9, ONE, TWO, 1'b1, iss, pop, h);
    n_checks++; if (iss !== 1'b0) $display("FAIL full_no_credit: issue %b want 0", iss); else n_pass++;
    n_checks++; if (pop !== 1'b1) $display("FAIL full_pop: got %b want 1", pop); else n_pass++;
    if (pop && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (h !== e) $display("FAIL full_head: got %h want %h", h, e); else n_pass++;
    end
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL full_credit_back: got %b want 1", req_ready_o); else n_pass++;
    n_checks++; if (res_tag_o !== 5'd1) $display("FAIL full_head_adv: got %0d want 1", res_tag_o); else n_pass++;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step(1'b0, 5'd0, ONE, ONE, 1'b1, iss, pop, h);
      if (pop && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (h !== e) $display("FAIL drain_order: got %h want %h", h, e); else n_pass++;
      end
      n++;
    end
    n_checks++; if (sb.size() != 0) $display("FAIL drain_timeout: %0d left want 0", sb.size()); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL drain_empty: got %b want 0", res_valid_o); else n_pass++;
  endtask

  task automatic test_stream();
    logic iss, pop; div_res_t h, e; int n_miss, n_pop, n;
    n_miss = 0; n_pop = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'(i), tbl[i % 4], tbl[(i / 4) % 4], 1'b1, iss, pop, h);
      if (!iss) n_miss++;
      if (pop && sb.size() > 0) begin
        e = sb.pop_front(); n_pop++;
        n_checks++; if (h !== e) $display("FAIL stream_data: got %h want %h", h, e); else n_pass++;
      end
    end
    n_checks++; if (n_miss != 0) $display("FAIL stream_issue_rate: %0d missed want 0", n_miss); else n_pass++;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step(1'b0, 5'd0, ONE, ONE, 1'b1, iss, pop, h);
      if (pop && sb.size() > 0) begin
        e = sb.pop_front(); n_pop++;
        n_checks++; if (h !== e) $display("FAIL stream_tail: got %h want %h", h, e); else n_pass++;
      end
      n++;
    end
    n_checks++; if (n_pop != 20) $display("FAIL stream_count: got %0d want 20", n_pop); else n_pass++;
  endtask

  task automatic test_spurious();
    logic iss, pop; div_res_t h;
    n_checks++; if (err_o !== 1'b0) $display("FAIL spur_pre: got %b want 0", err_o); else n_pass++;
    inj = 1'b1;
    step(1'b0, 5'd0, ONE, ONE, 1'b0, iss, pop, h);
    inj = 1'b0;
    n_checks++; if (err_o !== 1'b1) $display("FAIL spur_err: got %b want 1", err_o); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL spur_dropped: got %b want 0", res_valid_o); else n_pass++;
    repeat (3) step(1'b0, 5'd0, ONE, ONE, 1'b1, iss, pop, h);
    n_checks++; if (err_o !== 1'b1) $display("FAIL spur_sticky: got %b want 1", err_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL spur_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic iss, pop; div_res_t h, e; int n; logic got;
    for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), tbl[i], TWO, 1'b0, iss, pop, h);
    repeat (3) step(1'b0, 5'd0, ONE, ONE, 1'b0, iss, pop, h);
    step(1'b1, 5'd13, FOUR, TWO, 1'b0, iss, pop, h);
    n_checks++; if (iss !== 1'b1) $display("FAIL midop_issue: got %b want 1", iss); else n_pass++;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    #1;
    sb.delete();
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL midop_ready: got %b want 1", req_ready_o); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL midop_valid: got %b want 0", res_valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL midop_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL midop_err: got %b want 0", err_o); else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step(1'b0, 5'd0, ONE, ONE, 1'b0, iss, pop, h);
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL midop_flushed: got %b want 0", res_valid_o); else n_pass++;
    // Function resumes normally after reset.
    step(1'b1, 5'd7, FOUR, TWO, 1'b1, iss, pop, h);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      step(1'b0, 5'd0, ONE, ONE, 1'b1, iss, pop, h);
      if (pop && sb.size() > 0) begin
        got = 1'b1;
        e = sb.pop_front();
        n_checks++; if (h !== e) $display("FAIL post_reset_op: got %h want %h", h, e); else n_pass++;
        n_checks++; if (h.res !== TWO) $display("FAIL post_reset_value: got %h want %h", h.res, TWO); else n_pass++;
      end
      n++;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL post_reset_timeout: got %b want 1", got); else n_pass++;
  endtask

  initial begin
    tbl[0] = ONE; tbl[1] = TWO; tbl[2] = FOUR; tbl[3] = SIX;
    repeat (2) @(negedge clk_i);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_single_op();
    test_back_pressure();
    test_pop_at_full();
    test_stream();
    test_spurious();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
